// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// opcode/funct constants, datapath select encodings and the per-state control word.
package mc_defs;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // fetch/beq/jump/waitdone mark strobes that are finished off by memready or zero
  typedef struct packed {
    logic       memreq;
    logic       memwrite;
    logic       iord;
    logic       fetch;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    aluop_t     aluop;
    logic       beq;
    logic       jump;
    logic       done;
    logic       waitdone;
  } ctrl_t;

  function automatic logic op_legal(logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.memreq = 1'b1; c.fetch = 1'b1; c.alusrcb = SRCB_ONE; end
      DECODE:  c.alusrcb = SRCB_IMM;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; end
      MEMRD:   begin c.memreq = 1'b1; c.iord = 1'b1; end
      MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.done = 1'b1; end
      MEMWR:   begin c.memreq = 1'b1; c.memwrite = 1'b1; c.iord = 1'b1; c.waitdone = 1'b1; end
      RTYPEEX: begin c.alusrca = 1'b1; c.alusrcb = SRCB_REGB; c.aluop = ALUOP_FUNCT; end
      RTYPEWB: begin c.regwrite = 1'b1; c.regdst = 1'b1; c.done = 1'b1; end
      BEQEX:   begin
        c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = PCSRC_ALUOUT;
        c.beq = 1'b1; c.done = 1'b1;
      end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; end
      ADDIWB:  begin c.regwrite = 1'b1; c.done = 1'b1; end
      JEX:     begin c.pcsrc = PCSRC_JUMP; c.jump = 1'b1; c.done = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control-unit <-> datapath/memory bundle: instruction fields and flags in,
// mux selects and write strobes out.
interface mc_controller_if #(parameter int OPW = 6, parameter int FNW = 6);

  logic [OPW-1:0] op;
  logic [FNW-1:0] funct;
  logic           zero;
  logic           memready;

  logic           memreq;
  logic           memwrite;
  logic           iord;
  logic           irwrite;
  logic           pcen;
  logic           regwrite;
  logic           regdst;
  logic           memtoreg;
  logic           alusrca;
  logic [1:0]     alusrcb;
  logic [1:0]     pcsrc;
  logic [2:0]     alucontrol;
  logic           instr_done;
  logic           illegal;

  modport master (
    input  op, funct, zero, memready,
    output memreq, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, instr_done, illegal
  );

  modport slave (
    output op, funct, zero, memready,
    input  memreq, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, instr_done, illegal
  );

endinterface

// File: rtl/mc_controller_aludec.sv
// ALU decoder: turns the FSM's coarse ALU operation plus the R-type funct
// field into the 3-bit alucontrol code.
module mc_aludec
  import mc_defs::*;
#(
  parameter int FNW = 6
) (
  input  aluop_t         aluop,
  input  logic [FNW-1:0] funct,
  output logic [2:0]     alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute and drives every
// datapath select and strobe, handshaking with memory via memreq/memready.
module mc_controller
  import mc_defs::*;
#(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input logic            clk,
  input logic            reset,
  mc_controller_if.master bus
);

  state_t         state;
  state_t         nxt;
  ctrl_t          ctl;
  ctrl_t          eff;
  logic [OPW-1:0] opcode;
  logic           illegal_now;

  assign opcode = bus.op;

  always_comb begin
    nxt = state;
    case (state)
      FETCH:   if (bus.memready) nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = RTYPEEX;
          OP_BEQ:       nxt = BEQEX;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JEX;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:  nxt = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (bus.memready) nxt = MEMWB;
      MEMWR:   if (bus.memready) nxt = FETCH;
      RTYPEEX: nxt = RTYPEWB;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  // The control word is registered alongside the state so it always matches it
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ctl   <= state_ctrl(FETCH);
    end else begin
      state <= nxt;
      ctl   <= state_ctrl(nxt);
    end
  end

  // Reset shows FETCH selects immediately and squashes every strobe in that cycle
  assign eff         = reset ? state_ctrl(FETCH) : ctl;
  assign illegal_now = !reset && (state == DECODE) && !op_legal(opcode);

  assign bus.memreq     = !reset && eff.memreq;
  assign bus.memwrite   = !reset && eff.memwrite;
  assign bus.regwrite   = !reset && eff.regwrite;
  assign bus.irwrite    = !reset && eff.fetch && bus.memready;
  assign bus.pcen       = !reset && ((eff.fetch && bus.memready) ||
                                     (eff.beq && bus.zero) || eff.jump);
  assign bus.instr_done = (!reset && (eff.done || (eff.waitdone && bus.memready))) ||
                          illegal_now;
  assign bus.illegal    = illegal_now;

  assign bus.iord     = eff.iord;
  assign bus.regdst   = eff.regdst;
  assign bus.memtoreg = eff.memtoreg;
  assign bus.alusrca  = eff.alusrca;
  assign bus.alusrcb  = eff.alusrcb;
  assign bus.pcsrc    = eff.pcsrc;

  mc_aludec #(.FNW(FNW)) u_aludec (
    .aluop      (eff.aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: builds the expected per-cycle output trace
// of each instruction from the instruction-level rules and checks every cycle.
module tb_mc_controller;

  typedef struct packed {
    logic       memreq;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done;
    logic       illegal;
  } outT;

  typedef struct {
    outT        exp;
    logic       rdy;
    logic       z;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
  } stepT;

  typedef struct {
    outT exp;
    int  idx;
  } expT;

  logic  clk;
  logic  reset;
  int    errors;
  int    checks;
  int    doneCount;
  int    lastDone;
  string curLabel;
  stepT  plan[$];
  expT   expQ[$];
  outT   seen[$];
  logic [5:0] pOp;
  logic [5:0] pFunct;

  mc_controller_if #(.OPW(6), .FNW(6)) bus ();

  mc_controller #(.OPW(6), .FNW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input outT act, input outT exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic outT seenAt(input int i);
    outT o;
    o = 'x;
    if (i >= 0 && i < seen.size()) o = seen[i];
    return o;
  endfunction

  function automatic outT base();
    outT o;
    o = '0;
    o.alucontrol = 3'b010;
    return o;
  endfunction

  function automatic logic [2:0] expAlu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  task automatic addStep(input outT e, input logic rdy, input logic z, input logic rst);
    stepT s;
    s.exp = e; s.rdy = rdy; s.z = z; s.rst = rst; s.op = pOp; s.funct = pFunct;
    plan.push_back(s);
  endtask

  // Expected trace of one instruction: fetch waits, decode, then the op-specific steps
  task automatic queueInstr(input logic [5:0] op, input logic [5:0] funct,
                            input logic z, input int fw, input int mw);
    outT e;
    pOp = op; pFunct = funct;
    for (int i = 0; i < fw; i++) begin
      e = base(); e.memreq = 1; e.alusrcb = 2'b01; addStep(e, 1'b0, z, 1'b0);
    end
    e = base(); e.memreq = 1; e.alusrcb = 2'b01; e.irwrite = 1; e.pcen = 1;
    addStep(e, 1'b1, z, 1'b0);
    e = base(); e.alusrcb = 2'b10;
    if (!(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})) begin
      e.illegal = 1; e.instr_done = 1; addStep(e, 1'b1, z, 1'b0);
      return;
    end
    addStep(e, 1'b1, z, 1'b0);
    case (op)
      6'b100011, 6'b101011: begin
        e = base(); e.alusrca = 1; e.alusrcb = 2'b10; addStep(e, 1'b1, z, 1'b0);
        for (int i = 0; i <= mw; i++) begin
          e = base(); e.memreq = 1; e.iord = 1;
          e.memwrite = (op == 6'b101011);
          e.instr_done = (op == 6'b101011) && (i == mw);
          addStep(e, (i == mw), z, 1'b0);
        end
        if (op == 6'b100011) begin
          e = base(); e.regwrite = 1; e.memtoreg = 1; e.instr_done = 1;
          addStep(e, 1'b1, z, 1'b0);
        end
      end
      6'b000000: begin
        e = base(); e.alusrca = 1; e.alucontrol = expAlu(funct); addStep(e, 1'b1, z, 1'b0);
        e = base(); e.regwrite = 1; e.regdst = 1; e.instr_done = 1; addStep(e, 1'b1, z, 1'b0);
      end
      6'b000100: begin
        e = base(); e.alusrca = 1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
        e.pcen = z; e.instr_done = 1; addStep(e, 1'b1, z, 1'b0);
      end
      6'b001000: begin
        e = base(); e.alusrca = 1; e.alusrcb = 2'b10; addStep(e, 1'b1, z, 1'b0);
        e = base(); e.regwrite = 1; e.instr_done = 1; addStep(e, 1'b1, z, 1'b0);
      end
      default: begin
        e = base(); e.pcsrc = 2'b10; e.pcen = 1; e.instr_done = 1; addStep(e, 1'b1, z, 1'b0);
      end
    endcase
  endtask

  task automatic applyStimulus(input string label);
    expT x;
    curLabel = label; doneCount = 0; lastDone = -1; seen.delete();
    for (int i = 0; i < plan.size(); i++) begin
      @(posedge clk); #1;
      reset = plan[i].rst; bus.memready = plan[i].rdy; bus.zero = plan[i].z;
      bus.op = plan[i].op; bus.funct = plan[i].funct;
      x.exp = plan[i].exp; x.idx = i;
      expQ.push_back(x);
    end
    @(negedge clk); #1;
    plan.delete();
  endtask

  task automatic runInstr(input string label, input logic [5:0] op, input logic [5:0] funct,
                          input logic z, input int fw, input int mw, input int latency);
    queueInstr(op, funct, z, fw, mw);
    applyStimulus(label);
    checkInt({label, " latency"}, lastDone + 1, latency);
    checkInt({label, " done pulses"}, doneCount, 1);
  endtask

  // Single compare process: every cycle with a queued expectation is checked
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expT x;
      outT act;
      x = expQ.pop_front();
      act = '{bus.memreq, bus.memwrite, bus.iord, bus.irwrite, bus.pcen, bus.regwrite,
              bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc,
              bus.alucontrol, bus.instr_done, bus.illegal};
      seen.push_back(act);
      if (bus.instr_done === 1'b1) begin
        doneCount++;
        lastDone = x.idx;
      end
      checkOutput($sformatf("%s cycle %0d", curLabel, x.idx), act, x.exp);
    end
  end

  initial begin
    outT e;
    int  cnt;
    logic [5:0] functs [6];
    errors = 0; checks = 0;
    reset = 1'b1; bus.memready = 1'b0; bus.zero = 1'b0; bus.op = '0; bus.funct = '0;
    pOp = '0; pFunct = '0;

    e = base(); e.alusrcb = 2'b01;
    addStep(e, 1'b0, 1'b0, 1'b1);
    addStep(e, 1'b1, 1'b0, 1'b1);
    applyStimulus("reset");

    runInstr("lw", 6'b100011, 6'b0, 1'b0, 0, 0, 5);
    checkInt("lw c0 irwrite+pcen", int'(seenAt(0).irwrite & seenAt(0).pcen), 1);
    checkInt("lw c4 regwrite+memtoreg", int'(seenAt(4).regwrite & seenAt(4).memtoreg), 1);

    runInstr("slt", 6'b000000, 6'b101010, 1'b0, 0, 0, 4);
    checkInt("slt alucontrol", int'(seenAt(2).alucontrol), 7);
    checkInt("slt wb regdst", int'(seenAt(3).regdst & seenAt(3).regwrite), 1);

    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b111111, 6'b000000};
    foreach (functs[i]) runInstr($sformatf("rtype f=%b", functs[i]), 6'b000000, functs[i], 1'b0, 0, 0, 4);

    runInstr("beq taken", 6'b000100, 6'b0, 1'b1, 0, 0, 3);
    checkInt("beq taken pcen", int'(seenAt(2).pcen), 1);
    checkInt("beq taken pcsrc", int'(seenAt(2).pcsrc), 1);
    runInstr("beq not taken", 6'b000100, 6'b0, 1'b0, 0, 0, 3);
    checkInt("beq not taken pcen", int'(seenAt(2).pcen), 0);

    runInstr("sw wait3", 6'b101011, 6'b0, 1'b0, 0, 3, 7);
    cnt = 0;
    foreach (seen[i]) if (seen[i].memreq && seen[i].memwrite && seen[i].iord) cnt++;
    checkInt("sw request cycles", cnt, 4);
    cnt = 0;
    foreach (seen[i]) if (seen[i].regwrite) cnt++;
    checkInt("sw regwrite cycles", cnt, 0);

    runInstr("sw", 6'b101011, 6'b0, 1'b1, 0, 0, 4);
    runInstr("addi", 6'b001000, 6'b0, 1'b0, 0, 0, 4);
    runInstr("addi fetch wait2", 6'b001000, 6'b0, 1'b0, 2, 0, 6);
    runInstr("lw memrd wait2", 6'b100011, 6'b0, 1'b0, 0, 2, 7);
    runInstr("j", 6'b000010, 6'b0, 1'b0, 0, 0, 3);
    runInstr("illegal", 6'b111111, 6'b0, 1'b0, 0, 0, 2);
    checkInt("illegal pulse", int'(seenAt(1).illegal & seenAt(1).instr_done), 1);
    runInstr("illegal 010101", 6'b010101, 6'b0, 1'b1, 1, 0, 3);

    // Reset while MEMRD waits on memory: abandon the load, restart fetch afterwards
    pOp = 6'b100011; pFunct = '0;
    e = base(); e.memreq = 1; e.alusrcb = 2'b01; e.irwrite = 1; e.pcen = 1;
    addStep(e, 1'b1, 1'b0, 1'b0);
    e = base(); e.alusrcb = 2'b10; addStep(e, 1'b1, 1'b0, 1'b0);
    e = base(); e.alusrca = 1; e.alusrcb = 2'b10; addStep(e, 1'b1, 1'b0, 1'b0);
    e = base(); e.memreq = 1; e.iord = 1; addStep(e, 1'b0, 1'b0, 1'b0);
    e = base(); e.alusrcb = 2'b01; addStep(e, 1'b0, 1'b0, 1'b1);
    queueInstr(6'b100011, 6'b0, 1'b0, 1, 0);
    applyStimulus("reset in memrd");
    checkInt("reset cycle memreq", int'(seenAt(4).memreq), 0);
    checkInt("post-reset memreq", int'(seenAt(5).memreq), 1);
    checkInt("reset run done pulses", doneCount, 1);

    runInstr("j after reset", 6'b000010, 6'b0, 1'b0, 0, 0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
